// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver with a small command-frame parser.
// Frame: 0xAA header, command byte, data byte, and optionally a checksum byte.
// Define UART_CMD_RX_CHKSUM_EN to require the checksum byte (cmd + data, mod 256);
// without it, frames are three bytes and the adder is not built.
//
// Byte FSM
//   state   | meaning
//   S_IDLE  | line idle, waiting for a synchronized falling edge
//   S_START | timing to mid start bit; high sample rejects the edge as a glitch
//   S_DATA  | sampling 8 data bits, LSB first, one bit period apart
//   S_STOP  | sampling the stop bit; after a low stop, holds until the line is high
//
// Frame FSM
//   state   | meaning
//   F_HDR   | hunting for the 0xAA header, other bytes dropped
//   F_CMD   | next byte is the command
//   F_DAT   | next byte is the data
//   F_SUM   | next byte is the checksum (checksum build only)
module uart_cmd_rx #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 9600,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       cmd_valid,
    output logic [7:0] cmd_code,
    output logic [7:0] cmd_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int BW           = $clog2(CLKS_PER_BIT + 1);
    localparam int TW           = $clog2(TO_CYCLES + 1);

    localparam logic [BW-1:0] L_BIT_RELOAD  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] L_HALF_RELOAD = BW'(HALF_BIT - 1);
    localparam logic [TW-1:0] L_TO_RELOAD   = TW'(TO_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} byte_state_t;
    typedef enum logic [1:0] {F_HDR, F_CMD, F_DAT, F_SUM} frame_state_t;

    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_rx_prev;
    logic          w_fall;

    byte_state_t   r_bstate;
    logic [BW-1:0] r_btmr;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_byte;
    logic          r_byte_valid;
    logic          r_stop_err;
    logic          r_wait_high;

    frame_state_t  r_fstate;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_cmd_b;
    logic [7:0]    r_cmd_code;
    logic [7:0]    r_cmd_data;
    logic          r_cmd_valid;
    logic          r_frame_err;

`ifdef UART_CMD_RX_CHKSUM_EN
    logic [7:0]    r_dat_b;
    logic [7:0]    w_sum;
    assign w_sum = r_cmd_b + r_dat_b;
`endif

    assign w_fall = r_rx_prev & ~r_rx_sync;

    // Two-flop synchronizer plus one delay stage for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Byte FSM: mid-bit sampling driven by a down-counting bit timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bstate     <= S_IDLE;
            r_btmr       <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_rx_byte    <= '0;
            r_byte_valid <= 1'b0;
            r_stop_err   <= 1'b0;
            r_wait_high  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_stop_err   <= 1'b0;
            case (r_bstate)
                S_IDLE: begin
                    if (w_fall) begin
                        r_bstate <= S_START;
                        r_btmr   <= L_HALF_RELOAD;
                    end
                end
                S_START: begin
                    if (r_btmr == '0) begin
                        if (!r_rx_sync) begin
                            r_bstate  <= S_DATA;
                            r_btmr    <= L_BIT_RELOAD;
                            r_bit_idx <= '0;
                        end else begin
                            r_bstate <= S_IDLE;
                        end
                    end else begin
                        r_btmr <= r_btmr - 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_btmr == '0) begin
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        r_btmr  <= L_BIT_RELOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_bstate <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_btmr <= r_btmr - 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_wait_high) begin
                        // A broken stop bit may be a long break; do not rearm until the line recovers
                        if (r_rx_sync) begin
                            r_wait_high <= 1'b0;
                            r_bstate    <= S_IDLE;
                        end
                    end else if (r_btmr == '0) begin
                        if (r_rx_sync) begin
                            r_rx_byte    <= r_shift;
                            r_byte_valid <= 1'b1;
                            r_bstate     <= S_IDLE;
                        end else begin
                            r_stop_err  <= 1'b1;
                            r_wait_high <= 1'b1;
                        end
                    end else begin
                        r_btmr <= r_btmr - 1'b1;
                    end
                end
                default: r_bstate <= S_IDLE;
            endcase
        end
    end

    // Frame FSM: header hunt, field capture, checksum, inter-byte timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fstate    <= F_HDR;
            r_to_cnt    <= '0;
            r_cmd_b     <= '0;
`ifdef UART_CMD_RX_CHKSUM_EN
            r_dat_b     <= '0;
`endif
            r_cmd_code  <= '0;
            r_cmd_data  <= '0;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            // The branches are exclusive, so cmd_valid and frame_err never coincide
            if (r_byte_valid) begin
                r_to_cnt <= L_TO_RELOAD;
                case (r_fstate)
                    F_HDR: begin
                        if (r_rx_byte == 8'hAA) begin
                            r_fstate <= F_CMD;
                        end
                    end
                    F_CMD: begin
                        r_cmd_b  <= r_rx_byte;
                        r_fstate <= F_DAT;
                    end
`ifdef UART_CMD_RX_CHKSUM_EN
                    F_DAT: begin
                        r_dat_b  <= r_rx_byte;
                        r_fstate <= F_SUM;
                    end
                    F_SUM: begin
                        if (r_rx_byte == w_sum) begin
                            r_cmd_code  <= r_cmd_b;
                            r_cmd_data  <= r_dat_b;
                            r_cmd_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_fstate <= F_HDR;
                    end
`else
                    F_DAT: begin
                        r_cmd_code  <= r_cmd_b;
                        r_cmd_data  <= r_rx_byte;
                        r_cmd_valid <= 1'b1;
                        r_fstate    <= F_HDR;
                    end
`endif
                    default: r_fstate <= F_HDR;
                endcase
            end else if (r_stop_err) begin
                r_frame_err <= 1'b1;
                r_fstate    <= F_HDR;
                r_to_cnt    <= L_TO_RELOAD;
            end else if (r_fstate != F_HDR && r_bstate == S_IDLE) begin
                if (r_to_cnt == '0) begin
                    r_frame_err <= 1'b1;
                    r_fstate    <= F_HDR;
                    r_to_cnt    <= L_TO_RELOAD;
                end else begin
                    r_to_cnt <= r_to_cnt - 1'b1;
                end
            end else begin
                r_to_cnt <= L_TO_RELOAD;
            end
        end
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd_code   = r_cmd_code;
    assign cmd_data   = r_cmd_data;
    assign byte_valid = r_byte_valid;
    assign rx_byte    = r_rx_byte;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 16 clocks per bit; follows the
// UART_CMD_RX_CHKSUM_EN setting of the build (4-byte or 3-byte frames).
`timescale 1ns/1ps

`ifdef UART_CMD_RX_CHKSUM_EN
`define TB_SUM(s) send_byte(s, 1'b1)
`else
`define TB_SUM(s)
`endif

module tb_uart_cmd_rx;

    localparam int CPB = 16;
    localparam int TO_BITS = 20;
`ifdef UART_CMD_RX_CHKSUM_EN
    localparam int FRAME_BYTES = 4;
`else
    localparam int FRAME_BYTES = 3;
`endif

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic [7:0] cmd_data;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_cmd = 0;
    int n_bv = 0;
    int n_err = 0;
    int n_both = 0;

    uart_cmd_rx #(
        .CLK_FREQ    (1600000),
        .BAUD        (100000),
        .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_data  (cmd_data),
        .byte_valid(byte_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (cmd_valid) n_cmd <= n_cmd + 1;
        if (byte_valid) n_bv <= n_bv + 1;
        if (frame_err) n_err <= n_err + 1;
        if (cmd_valid && frame_err) n_both <= n_both + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_bits(input int nbits);
        rx = 1'b1;
        repeat (nbits * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    int c0, b0, e0, el;
    bit seen;

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        check_eq("rst_cmd_code", 32'(cmd_code), 32'h00);
        check_eq("rst_cmd_data", 32'(cmd_data), 32'h00);
        check_eq("rst_byte_valid", 32'(byte_valid), 32'h0);
        check_eq("rst_rx_byte", 32'(rx_byte), 32'h00);
        check_eq("rst_frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        idle_bits(2);

        // Basic frame
        c0 = n_cmd; b0 = n_bv; e0 = n_err;
        send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h5A, 1'b1); `TB_SUM(8'h5B);
        idle_bits(2);
        check_eq("f1_cmd_cnt", 32'(n_cmd - c0), 32'd1);
        check_eq("f1_byte_cnt", 32'(n_bv - b0), 32'(FRAME_BYTES));
        check_eq("f1_code", 32'(cmd_code), 32'h01);
        check_eq("f1_data", 32'(cmd_data), 32'h5A);
        check_eq("f1_no_err", 32'(n_err - e0), 32'd0);

        // Checksum wrap case
        c0 = n_cmd;
        send_byte(8'hAA, 1'b1); send_byte(8'h80, 1'b1); send_byte(8'h90, 1'b1); `TB_SUM(8'h10);
        idle_bits(2);
        check_eq("f2_cmd_cnt", 32'(n_cmd - c0), 32'd1);
        check_eq("f2_code", 32'(cmd_code), 32'h80);
        check_eq("f2_data", 32'(cmd_data), 32'h90);

`ifdef UART_CMD_RX_CHKSUM_EN
        // Bad checksum keeps previous command
        c0 = n_cmd; e0 = n_err;
        send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h04, 1'b1);
        idle_bits(2);
        check_eq("sum_err_cnt", 32'(n_err - e0), 32'd1);
        check_eq("sum_no_cmd", 32'(n_cmd - c0), 32'd0);
        check_eq("sum_code_held", 32'(cmd_code), 32'h80);
        check_eq("sum_data_held", 32'(cmd_data), 32'h90);
`endif

        // Short low glitch, then junk byte before a frame
        b0 = n_bv; e0 = n_err;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        idle_bits(2);
        check_eq("glitch_no_byte", 32'(n_bv - b0), 32'd0);
        check_eq("glitch_no_err", 32'(n_err - e0), 32'd0);
        c0 = n_cmd;
        send_byte(8'h33, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); `TB_SUM(8'h05);
        idle_bits(2);
        check_eq("junk_byte_cnt", 32'(n_bv - b0), 32'(FRAME_BYTES + 1));
        check_eq("junk_cmd_cnt", 32'(n_cmd - c0), 32'd1);
        check_eq("junk_code", 32'(cmd_code), 32'h02);
        check_eq("junk_data", 32'(cmd_data), 32'h03);

        // Inter-byte timeout: expires ~320 idle cycles after the last stop sample
        c0 = n_cmd; e0 = n_err;
        send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b1);
        seen = 1'b0; el = 25 * CPB;
        for (int i = 0; i < 25 * CPB; i++) begin
            @(negedge clk);
            if (!seen && n_err != e0) begin
                seen = 1'b1;
                el = i;
            end
        end
        check_eq("to_err_cnt", 32'(n_err - e0), 32'd1);
        check_eq("to_window", 32'(el >= 300 && el <= 330), 32'd1);
        check_eq("to_no_cmd", 32'(n_cmd - c0), 32'd0);
        send_byte(8'hAA, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1); `TB_SUM(8'h07);
        idle_bits(2);
        check_eq("to_next_cmd", 32'(n_cmd - c0), 32'd1);
        check_eq("to_next_code", 32'(cmd_code), 32'h03);

        // Broken stop bit
        c0 = n_cmd; b0 = n_bv; e0 = n_err;
        send_byte(8'h55, 1'b0);
        idle_bits(2);
        check_eq("stop_err_cnt", 32'(n_err - e0), 32'd1);
        check_eq("stop_no_byte", 32'(n_bv - b0), 32'd0);
        send_byte(8'hAA, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h06, 1'b1); `TB_SUM(8'h0B);
        idle_bits(2);
        check_eq("stop_next_cmd", 32'(n_cmd - c0), 32'd1);
        check_eq("stop_next_code", 32'(cmd_code), 32'h05);

        // Reset in the middle of the data byte
        send_byte(8'hAA, 1'b1); send_byte(8'h07, 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        check_eq("mid_rst_code", 32'(cmd_code), 32'h00);
        idle_bits(2);
        c0 = n_cmd;
        send_byte(8'hAA, 1'b1); send_byte(8'h09, 1'b1); send_byte(8'h0A, 1'b1); `TB_SUM(8'h13);
        idle_bits(2);
        check_eq("post_rst_cmd", 32'(n_cmd - c0), 32'd1);
        check_eq("post_rst_code", 32'(cmd_code), 32'h09);
        check_eq("post_rst_data", 32'(cmd_data), 32'h0A);

        check_eq("valid_err_overlap", 32'(n_both), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD, truncated (5208 at default).
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20, maximum idle gap in bit periods between bytes of one frame.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rx, input, 1, asynchronous UART line (8N1, LSB first, idle high).
REQ-007 SHALL have port cmd_valid, output, 1, one-cycle pulse when a complete, valid frame is accepted.
REQ-008 SHALL have port cmd_code, output, 8, command byte of the last valid frame.
REQ-009 SHALL have port cmd_data, output, 8, data byte of the last valid frame.
REQ-010 SHALL have port byte_valid, output, 1, one-cycle pulse per correctly stopped byte.
REQ-011 SHALL have port rx_byte, output, 8, last received byte.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit, checksum mismatch or inter-byte timeout.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer before any use; synchronized-edge detection adds 2-3 cycles of input latency.
REQ-014 Byte FSM SHALL use states IDLE, START, DATA, STOP; IDLE->START on synchronized falling edge.
REQ-015 START SHALL resample at CLKS_PER_BIT/2; a high sample returns to IDLE with no pulse (glitch rejection).
REQ-016 DATA SHALL sample 8 bits at CLKS_PER_BIT intervals from mid-start, LSB first, into a shift register.
REQ-017 STOP SHALL sample one bit period after bit 7; high -> rx_byte updated, byte_valid pulses the next cycle; low -> frame_err pulses, byte discarded, FSM waits for rx high before IDLE.
REQ-018 Frame FSM SHALL use states F_HDR, F_CMD, F_DAT, F_SUM and advance only on byte_valid.
REQ-019 F_HDR SHALL accept only 0xAA; any other byte is silently dropped.
REQ-020 F_SUM SHALL compare the byte with (cmd + data) mod 256, 8-bit wrap; on match, update cmd_code/cmd_data and pulse cmd_valid in the cycle after byte_valid; on mismatch, pulse frame_err; both cases return to F_HDR.
REQ-021 A 0xAA received in F_CMD, F_DAT or F_SUM SHALL be treated as data, not as a resync.
REQ-022 In any state other than F_HDR, a gap over TIMEOUT_BITS*CLKS_PER_BIT cycles with byte FSM in IDLE SHALL pulse frame_err and return to F_HDR.
REQ-023 A stop-bit error inside a frame SHALL also return the frame FSM to F_HDR.
REQ-024 cmd_valid and frame_err SHALL never assert in the same cycle.
REQ-025 cmd_code/cmd_data SHALL hold their values until the next valid frame.

Reset
REQ-026 On rst_n low, all state SHALL be cleared immediately: byte FSM IDLE, frame FSM F_HDR, counters 0, synchronizer flops 1.
REQ-027 Reset values SHALL be: cmd_valid 0, cmd_code 0x00, cmd_data 0x00, byte_valid 0, rx_byte 0x00, frame_err 0.
REQ-028 Reset asserted mid-byte or mid-frame SHALL discard the partial data; after release, the first falling edge starts a new byte.

Configuration
REQ-029 Macro UART_CMD_RX_CHKSUM_EN defined: 4-byte frame (AA, cmd, data, sum), F_SUM active as in REQ-020.
REQ-030 Macro UART_CMD_RX_CHKSUM_EN undefined: 3-byte frame (AA, cmd, data); F_SUM and the adder are removed; cmd_valid pulses the cycle after the data byte's byte_valid; frame_err comes only from stop-bit errors and timeouts.

Verification
REQ-031 Checksum enabled, 9600 baud, send AA 01 5A 5B -> one cmd_valid, cmd_code=0x01, cmd_data=0x5A, no frame_err.
REQ-032 Send AA 80 90 10 (sum wraps 0x110 -> 0x10) -> cmd_valid, cmd_code=0x80, cmd_data=0x90; then send AA 01 02 04 -> frame_err, cmd_code still 0x80.
REQ-033 Drive 1000-cycle low glitch on rx, then send 33 AA 02 03 05 -> no byte from glitch, 0x33 dropped, cmd_valid with cmd_code=0x02.
REQ-034 Send AA 01 then idle 25 bit periods -> frame_err at 20-bit mark; following AA 03 04 07 -> cmd_valid, cmd_code=0x03.
REQ-035 Send byte 0x55 with stop bit forced low -> frame_err, no byte_valid; next AA 05 06 0B -> cmd_valid.
REQ-036 Assert rst_n low during data byte of AA 07 08 0F, release, send AA 09 0A 13 -> only cmd_code=0x09 reported; rebuild without the macro and send AA 09 0A -> cmd_valid, cmd_data=0x0A.
